// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 register bank in the clk domain; SPI_REGS_READBACK_EN enables MISO readback
module spi_reg_slave #(
  parameter int ADDR_W = 3,
  localparam int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic                  sclk_sync,
  input  logic                  cs_n_sync,
  input  logic                  mosi_sync,
  output logic                  miso,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr
);
  localparam logic [1:0] IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [6:0] rx;
  logic [6:0] addr;
  logic       is_wr;
  logic       sclk_prev;
  logic       strobe;
  logic       rise;
  logic [7:0] frame_byte;
  logic       cmd_done;
  logic       commit;
  assign rise       = sclk_sync & ~sclk_prev;
  assign frame_byte = {rx, mosi_sync};
  assign cmd_done   = state == CMD && !cs_n_sync && rise && cnt == 4'd7;
  assign commit     = state == DATA && !cs_n_sync && rise && cnt == 4'd15 && is_wr && (addr >> ADDR_W) == 7'd0;
  assign wr_strobe  = strobe & ena;
  // frame decode FSM, register bank and write commit
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state     <= IDLE;
      cnt       <= '0;
      rx        <= '0;
      addr      <= '0;
      is_wr     <= 1'b0;
      sclk_prev <= 1'b0;
      strobe    <= 1'b0;
      regs_out  <= '0;
      wr_addr   <= '0;
    end else begin
      strobe <= ena & commit;
      if (ena) begin
        sclk_prev <= sclk_sync;
        if (state == IDLE) begin
          if (!cs_n_sync) begin
            state <= CMD;
            cnt   <= '0;
            rx    <= '0;
          end
        end else if (state == DONE) begin
          if (cs_n_sync) state <= IDLE;
        end else if (cs_n_sync) begin
          state <= IDLE;
        end else if (rise) begin
          rx  <= frame_byte[6:0];
          cnt <= cnt == 4'd15 ? cnt : cnt + 4'd1;
          if (cmd_done) begin
            state <= DATA;
            is_wr <= frame_byte[7];
            addr  <= frame_byte[6:0];
          end
          if (state == DATA && cnt == 4'd15) state <= DONE;
          if (commit) begin
            regs_out[{addr[ADDR_W-1:0], 3'b000} +: 8] <= frame_byte;
            wr_addr <= addr[ADDR_W-1:0];
          end
        end
      end
    end
  end
`ifdef SPI_REGS_READBACK_EN
  logic [7:0] tx;
  logic       fall;
  assign fall = ~sclk_sync & sclk_prev;
  assign miso = state == DATA && tx[7];
  // tx load on the 8th rise; the fall right after the load is skipped so bit7 is held for the 9th rise
  always_ff @(posedge clk) begin
    if (!rstb) tx <= '0;
    else if (ena) begin
      if (state == IDLE && !cs_n_sync) tx <= '0;
      else if (cmd_done) tx <= (!frame_byte[7] && (frame_byte[6:0] >> ADDR_W) == 7'd0) ? regs_out[{frame_byte[ADDR_W-1:0], 3'b000} +: 8] : 8'h00;
      else if (state == DATA && !cs_n_sync && fall && cnt != 4'd8) tx <= {tx[6:0], 1'b0};
    end
  end
`else
  assign miso = 1'b0;
`endif
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: directed SPI frames checked against a register-bank model every cycle
module tb_spi_reg_slave;
  logic        clk = 1'b0;
  logic        rstb, ena, sclk, cs_n, mosi;
  logic        miso, wr_strobe;
  logic [63:0] regs_out;
  logic [2:0]  wr_addr;
  logic [63:0] exp_regs = '0;
  logic        exp_strobe = 1'b0;
  logic [2:0]  exp_addr = '0;
  logic        miso_dc = 1'b0;
  logic        chk_en = 1'b0;
  int          n_tests = 0, n_fail = 0, n_strobe = 0;
  logic [7:0]  rd;
  int          s0;

  spi_reg_slave #(.ADDR_W(3)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .sclk_sync(sclk), .cs_n_sync(cs_n),
    .mosi_sync(mosi), .miso(miso), .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // cycle-by-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("regs_out", regs_out, exp_regs);
      chk("wr_strobe", {63'd0, wr_strobe}, {63'd0, exp_strobe});
      chk("wr_addr", {61'd0, wr_addr}, {61'd0, exp_addr});
      if (!miso_dc) chk("miso_idle", {63'd0, miso}, 64'd0);
      if (wr_strobe) n_strobe++;
    end
  end

  // one frame of nbits SCLK cycles (clk/8); rst_at >= 0 pulses rstb before that bit and stops the frame
  task automatic frame(input logic [15:0] f, input int nbits, input int rst_at, output logic [7:0] r);
    logic full;
    full = nbits >= 16 && rst_at < 0;
    r = '0;
    cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rstb = 1'b0;
        tick(1);
        rstb = 1'b1;
        exp_regs = '0;
        exp_addr = '0;
        miso_dc = 1'b0;
        break;
      end
      sclk = 1'b0;
      mosi = i < 16 ? f[15-i] : 1'b0;
      tick(4);
      if (i >= 8 && i < 16) r[15-i] = miso;
      if (i == 7 && !f[15] && full) miso_dc = 1'b1;
      sclk = 1'b1;
      if (i == 15 && full) begin
        tick(1);
        if (f[15] && f[14:8] < 7'd8) begin
          exp_regs[f[10:8]*8 +: 8] = f[7:0];
          exp_addr = f[10:8];
          exp_strobe = 1'b1;
        end
        tick(1);
        exp_strobe = 1'b0;
        tick(2);
        miso_dc = 1'b0;
      end else tick(4);
    end
    sclk = 1'b0;
    mosi = 1'b0;
    tick(4);
    cs_n = 1'b1;
    tick(6);
  endtask

  initial begin
    rstb = 1'b0; ena = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tick(2);
    chk_en = 1'b1;
    chk("rst_regs", regs_out, 64'd0);
    chk("rst_miso", {63'd0, miso}, 64'd0);
    chk("rst_strobe", {63'd0, wr_strobe}, 64'd0);
    chk("rst_addr", {61'd0, wr_addr}, 64'd0);
    rstb = 1'b1;
    tick(4);
    s0 = n_strobe;
    frame(16'h83A5, 16, -1, rd);
    chk("wr3_reg", {56'd0, regs_out[31:24]}, 64'hA5);
    chk("wr3_others", regs_out & ~64'hFF00_0000, 64'd0);
    chk("wr3_strobes", n_strobe - s0, 1);
    chk("wr3_addr", {61'd0, wr_addr}, 64'd3);
    frame(16'h0300, 16, -1, rd);
`ifdef SPI_REGS_READBACK_EN
    chk("rd3_miso", {56'd0, rd}, 64'hA5);
`else
    chk("rd3_miso", {56'd0, rd}, 64'h00);
`endif
    s0 = n_strobe;
    frame(16'h855A, 10, -1, rd);
    chk("abort_strobes", n_strobe - s0, 0);
    chk("abort_reg5", {56'd0, regs_out[47:40]}, 64'h00);
    frame(16'h8611, 16, -1, rd);
    chk("after_abort_reg6", {56'd0, regs_out[55:48]}, 64'h11);
    chk("after_abort_strobes", n_strobe - s0, 1);
    s0 = n_strobe;
    frame(16'h9077, 16, -1, rd);
    chk("oor_strobes", n_strobe - s0, 0);
    chk("oor_regs", regs_out, 64'h0011_0000_A500_0000);
    frame(16'h1000, 16, -1, rd);
    chk("oor_rd", {56'd0, rd}, 64'h00);
    s0 = n_strobe;
    frame(16'h8166, 20, -1, rd);
    chk("long_reg1", {56'd0, regs_out[15:8]}, 64'h66);
    chk("long_strobes", n_strobe - s0, 1);
    chk("long_addr", {61'd0, wr_addr}, 64'd1);
    frame(16'h82FF, 16, 12, rd);
    chk("rst_mid_regs", regs_out, 64'd0);
    chk("rst_mid_miso", {63'd0, miso}, 64'd0);
    chk("rst_mid_addr", {61'd0, wr_addr}, 64'd0);
    frame(16'h8244, 16, -1, rd);
    chk("post_rst_reg2", {56'd0, regs_out[23:16]}, 64'h44);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

SPI mode-0 register-bank peripheral that consumes the already double-flopped SPI pins (SCLK, CS_N, MOSI) from the input synchronizer stage and runs entirely in the system `clk` domain. It detects SCLK edges, decodes fixed 16-bit frames, and maintains a bank of 8-bit control registers exposed as a flat bus to the rest of the design. On read frames it serialises register contents back on MISO.

## Interface
- `ADDR_W`, default 3: register address width; `NUM_REGS = 2**ADDR_W`.
- `clk  in  1`: system clock; all logic on its rising edge.
- `rstb  in  1`: reset, synchronous, active-low.
- `ena  in  1`: clock enable; when low all state holds.
- `sclk_sync  in  1`: synchronized SPI clock.
- `cs_n_sync  in  1`: synchronized chip select, active-low.
- `mosi_sync  in  1`: synchronized MOSI.
- `miso  out  1`: serial read data.
- `regs_out  out  NUM_REGS*8`: register bank; reg k at bits [8k+7:8k].
- `wr_strobe  out  1`: one-cycle pulse on a committed write.
- `wr_addr  out  ADDR_W`: address of the last committed write.

## Operation
- Edge detect: `sclk_prev` registered when `ena`=1. rise = `sclk_sync & ~sclk_prev`, fall = `~sclk_sync & sclk_prev`. `sclk_prev` resets to 0.
- Frame, MSB first, sampled on rise: bit15 = R/W (1 = write), bits14:8 = address (7 bits), bits7:0 = data. Read frames ignore the data bits.
- Address ≥ `NUM_REGS`: upper address bits nonzero means out of range. Writes are discarded with no strobe. Reads return 0x00.
- FSM states:
  - IDLE: `cs_n_sync`=1. On `cs_n_sync`=0, clear the bit counter, rx shift register and tx shift register, then go to CMD.
  - CMD: shift 8 bits on rises. On the 8th rise, latch R/W and address. For a read, load tx with reg[addr] (or 0x00). Go to DATA.
  - DATA: shift 8 bits on rises. On the 16th rise, a valid write commits rx[7:0] to reg[addr]. Go to DONE.
  - DONE: ignore further SCLK edges until `cs_n_sync`=1, then go to IDLE.
- `cs_n_sync`=1 in CMD or DATA aborts the frame: no write, return to IDLE. This has priority over a simultaneous SCLK edge.
- MISO:
  - `miso` = tx[7].
  - tx shifts left (zero fill) on each fall while in DATA, except the fall that precedes the 9th rise is the first shift opportunity only after the load. The load occurs on the 8th rise, so bit7 is valid before the 9th rise.
  - `miso` is 0 in IDLE, CMD and DONE.
- The bit counter is 4 bits wide, 0..15, and does not wrap; DONE absorbs extra clocks.

## Timing
- Reset values: `miso`=0, `regs_out`=0, `wr_strobe`=0, `wr_addr`=0, FSM=IDLE, counters and shift registers 0.
- `rstb` low mid-frame: everything returns to the reset values on the next `clk` edge. A partial frame never commits.
- Edge-to-action: an SCLK edge visible on `sclk_sync` in cycle n is acted on at the end of cycle n. Register state is updated in cycle n+1.
- Write commit: `regs_out` shows the new value from cycle n+1. In that same cycle n+1, `wr_strobe`=1 for exactly one cycle and `wr_addr` is updated.
- `ena`=0 freezes the FSM, registers and `sclk_prev`. `wr_strobe` is forced to 0 while `ena`=0.
- SCLK constraints:
  - High and low phases must each be ≥ 4 `clk` cycles; SCLK ≤ clk/8 including synchronizer latency.
  - CS_N must be high for ≥ 4 `clk` cycles between frames.

## Configuration
- `SPI_REGS_READBACK_EN` defined: read frames load tx from the register bank as described above.
- `SPI_REGS_READBACK_EN` undefined: the tx path is removed, `miso` is tied to 0, and read frames complete with no side effects. Write behaviour is identical in both cases.

## Test plan
- Write frame 0x83A5 (write, addr 3, data 0xA5), SCLK = clk/8 -> `regs_out[31:24]`=0xA5, one `wr_strobe` pulse, `wr_addr`=3, other registers unchanged.
- After that write, read frame 0x0300 -> `miso` sampled on rises 9–16 gives 0xA5. With the macro undefined, all eight bits are 0.
- Write 0x855A, deasserting CS_N after 10 bits -> no `wr_strobe`, reg 5 stays 0x00, next full frame decodes correctly.
- Write 0x9077 (addr 0x10, out of range) -> no strobe, all registers unchanged. Read 0x1000 -> `miso` returns 0x00.
- Frame with 20 SCLK cycles, write 0x8166 -> reg 1 = 0x66 committed at the 16th rise. Extra clocks are ignored and produce exactly one strobe.
- `rstb` low for 1 cycle at bit 12 of write 0x82FF -> all outputs return to reset values, reg 2 = 0x00, `miso`=0.
